// File: rtl/codec_pkg.sv
// Shared defaults and types for the codec I2S playback path.
package codec_pkg;

    localparam int DEF_CLK_DIV  = 8;
    localparam int DEF_SAMPLE_W = 16;
    localparam int DEF_SLOT_W   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } tx_state_t;

    typedef logic signed [DEF_SAMPLE_W-1:0] sample_t;

    // Observation bundle; bit_cnt is zero-extended or truncated to 8 bits.
    typedef struct packed {
        tx_state_t  state;
        logic [7:0] bit_cnt;
        logic       pend_v;
        logic       bclk_rise;
        logic       bclk_fall;
    } tx_dbg_t;

endpackage

// File: rtl/codec_i2s_tx_if.sv
// Sample feed from the effect chain plus the I2S pins toward the DAC.
interface codec_i2s_tx_if #(
    parameter int SAMPLE_W = codec_pkg::DEF_SAMPLE_W
);
    // VALID is a one-clk strobe with no back-pressure: every clk with VALID=1 overwrites the
    // pending pair. smp_req pulses one clk after each frame load so the source can pace itself.
    logic                VALID;
    logic [SAMPLE_W-1:0] left_in;
    logic [SAMPLE_W-1:0] right_in;
    logic                smp_req;
    logic                BCLK;
    logic                LRCLK;
    logic                SDOUT;

    modport master (
        output VALID, left_in, right_in,
        input  smp_req, BCLK, LRCLK, SDOUT
    );

    modport slave (
        input  VALID, left_in, right_in,
        output smp_req, BCLK, LRCLK, SDOUT
    );

endinterface

// File: rtl/codec_bclk_gen.sv
// Bit-clock divider: toggles bclk every CLK_DIV clks while run is high, with edge strobes.
module codec_bclk_gen #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bclk,
    output logic rise_ev,
    output logic fall_ev
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             terminal;

    // Strobes coincide with the clk edge that moves bclk, so the top updates in lock-step.
    assign terminal = run && (div_cnt == DIV_LAST);
    assign rise_ev  = terminal && !bclk;
    assign fall_ev  = terminal && bclk;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/codec_i2s_tx.sv
// I2S playback transmitter: buffers one stereo pair, serialises it MSB-first with the
// one-BCLK I2S delay, repeats the last pair on underrun and stops cleanly at frame end.
module codec_i2s_tx
    import codec_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int SLOT_W   = DEF_SLOT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr_underrun,
    codec_i2s_tx_if.slave s_if,
    output logic          underrun,
    output tx_dbg_t       dbg
);

    localparam int FRAME_W = 2 * SLOT_W;
    localparam int BC_W    = $clog2(FRAME_W);
    localparam int IDX_W   = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(FRAME_W - 1);
    localparam logic [BC_W-1:0] SLOT_LEN = BC_W'(SLOT_W);

    tx_state_t           state;
    logic [BC_W-1:0]     bit_cnt;
    logic                lrclk_q;
    logic                sdout_q;
    logic                smp_req_q;
    logic [SAMPLE_W-1:0] pend_l;
    logic [SAMPLE_W-1:0] pend_r;
    logic                pend_v;
    logic [SAMPLE_W-1:0] held_l;
    logic [SAMPLE_W-1:0] held_r;

    logic                bclk;
    logic                rise_ev;
    logic                fall_ev;
    logic                frame_wrap;
    logic [BC_W-1:0]     nxt_bit;
    logic                nxt_lr;
    logic [BC_W-1:0]     slot_pos;
    logic [IDX_W-1:0]    sd_idx;
    logic [SAMPLE_W-1:0] tx_word;
    logic                nxt_sd;

    codec_bclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_bclk (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (state != IDLE),
        .bclk    (bclk),
        .rise_ev (rise_ev),
        .fall_ev (fall_ev)
    );

    assign frame_wrap = fall_ev && (bit_cnt == BIT_LAST);

    // Next bit position and the data bit it carries; slot bit 0 is the I2S delay slot.
    always_comb begin
        nxt_bit  = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        nxt_lr   = (nxt_bit >= SLOT_LEN);
        slot_pos = nxt_lr ? (nxt_bit - SLOT_LEN) : nxt_bit;
        tx_word  = nxt_lr ? held_r : held_l;
        sd_idx   = IDX_W'(SAMPLE_W - int'(slot_pos));
        nxt_sd   = 1'b0;
        if ((slot_pos != '0) && (int'(slot_pos) <= SAMPLE_W)) begin
            nxt_sd = tx_word[sd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= BIT_LAST;
            lrclk_q   <= 1'b0;
            sdout_q   <= 1'b0;
            smp_req_q <= 1'b0;
            pend_l    <= '0;
            pend_r    <= '0;
            pend_v    <= 1'b0;
            held_l    <= '0;
            held_r    <= '0;
            underrun  <= 1'b0;
        end else begin
            smp_req_q <= 1'b0;
            if (s_if.VALID) begin
                pend_l <= s_if.left_in;
                pend_r <= s_if.right_in;
                pend_v <= 1'b1;
            end
            if (clr_underrun) begin
                underrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    bit_cnt <= BIT_LAST;
                    lrclk_q <= 1'b0;
                    sdout_q <= 1'b0;
                    if (en) begin
                        state <= RUN;
                    end
                end
                RUN, DRAIN: begin
                    if (state == RUN && !en) begin
                        state <= DRAIN;
                    end else if (state == DRAIN && en) begin
                        state <= RUN;
                    end
                    if (fall_ev) begin
                        if (frame_wrap && state == DRAIN && !en) begin
                            // Drained: the frame-start load is skipped entirely.
                            state   <= IDLE;
                            bit_cnt <= BIT_LAST;
                            lrclk_q <= 1'b0;
                            sdout_q <= 1'b0;
                        end else begin
                            bit_cnt <= nxt_bit;
                            lrclk_q <= nxt_lr;
                            sdout_q <= nxt_sd;
                            if (frame_wrap) begin
                                smp_req_q <= 1'b1;
                                pend_v    <= 1'b0;
                                if (s_if.VALID) begin
                                    held_l <= s_if.left_in;
                                    held_r <= s_if.right_in;
                                end else if (pend_v) begin
                                    held_l <= pend_l;
                                    held_r <= pend_r;
                                end else begin
                                    underrun <= 1'b1;
                                end
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s_if.BCLK    = bclk;
    assign s_if.LRCLK   = lrclk_q;
    assign s_if.SDOUT   = sdout_q;
    assign s_if.smp_req = smp_req_q;

    always_comb begin
        dbg           = '0;
        dbg.state     = state;
        dbg.bit_cnt   = 8'(bit_cnt);
        dbg.pend_v    = pend_v;
        dbg.bclk_rise = rise_ev;
        dbg.bclk_fall = fall_ev;
    end

endmodule

// File: tb/tb_codec_i2s_tx.sv
// Bench for codec_i2s_tx: decodes SDOUT on BCLK rise into frames and checks them against a table.
module tb_codec_i2s_tx;
    import codec_pkg::*;

    localparam int CLK_DIV    = 2;
    localparam int SW         = DEF_SAMPLE_W;
    localparam int SL         = DEF_SLOT_W;
    localparam int FRAME_BITS = 2 * SL;
    localparam int FRAME_CLKS = 2 * CLK_DIV * FRAME_BITS;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        fmt_ok;
    } frame_t;

    // mode: 0 no VALID, 1 one VALID, 2 two VALIDs, 3 VALID on the load clk
    typedef struct {
        int      mode;
        sample_t l1;
        sample_t r1;
        sample_t l2;
        sample_t r2;
        sample_t exp_l;
        sample_t exp_r;
        logic    exp_ur;
        logic    clr;
    } vec_t;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    logic    en = 1'b0;
    logic    clr_underrun = 1'b0;
    logic    underrun;
    tx_dbg_t dbg;

    codec_i2s_tx_if sif ();

    codec_i2s_tx #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .clr_underrun (clr_underrun),
        .s_if         (sif.slave),
        .underrun     (underrun),
        .dbg          (dbg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Monitor state, updated on every falling clk edge
    int          idx = FRAME_BITS;
    int          since = 0;
    int          smp_cnt = 0;
    int          rise_cnt = 0;
    logic        prev_bclk = 1'b0;
    logic        lr_bits [FRAME_BITS];
    logic        sd_bits [FRAME_BITS];
    frame_t      got_q[$];
    logic [31:0] exp_q[$];

    function automatic frame_t decode();
        frame_t f;
        int     p;
        f.l = '0;
        f.r = '0;
        f.fmt_ok = 1'b1;
        for (int i = 0; i < FRAME_BITS; i++) begin
            p = i % SL;
            if (lr_bits[6'(i)] !== (i >= SL)) f.fmt_ok = 1'b0;
            if (p >= 1 && p <= SW) begin
                if (i < SL) f.l[4'(SW - p)] = sd_bits[6'(i)];
                else        f.r[4'(SW - p)] = sd_bits[6'(i)];
            end else if (sd_bits[6'(i)] !== 1'b0) begin
                f.fmt_ok = 1'b0;
            end
        end
        return f;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            idx = FRAME_BITS;
            since = 0;
            prev_bclk = 1'b0;
        end else begin
            if (sif.smp_req === 1'b1) begin
                idx = 0;
                since = 0;
                smp_cnt++;
            end else begin
                since++;
            end
            if (sif.BCLK === 1'b1 && prev_bclk === 1'b0) begin
                rise_cnt++;
                if (idx < FRAME_BITS) begin
                    lr_bits[6'(idx)] = sif.LRCLK;
                    sd_bits[6'(idx)] = sif.SDOUT;
                    idx++;
                    if (idx == FRAME_BITS) got_q.push_back(decode());
                end
            end
            prev_bclk = sif.BCLK;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_valid(input sample_t l, input sample_t r);
        sif.left_in  = l;
        sif.right_in = r;
        sif.VALID    = 1'b1;
        tick();
        sif.VALID    = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
    endtask

    task automatic wait_smp_req(input string tag, input int budget);
        int n = 0;
        while (sif.smp_req !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (sif.smp_req !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s_smp_req: no pulse within %0d clks", tag, budget);
        end else begin
            tick();
            check({tag, "_smp_req_width"}, 32'(sif.smp_req), 32'h0);
        end
    endtask

    task automatic wait_since(input string tag, input int target);
        int n = 0;
        while (since != target && n < FRAME_CLKS + 8) begin
            tick();
            n++;
        end
        check({tag, "_since"}, 32'(since), 32'(target));
    endtask

    task automatic wait_frame(input string tag);
        int          n = 0;
        frame_t      f;
        logic [31:0] e;
        while (got_q.size() == 0 && n < FRAME_CLKS + 64) begin
            tick();
            n++;
        end
        if (got_q.size() == 0 || exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_frame: got %0d frames, %0d expected pending", tag, got_q.size(),
                     exp_q.size());
        end else begin
            f = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_left"}, 32'(f.l), 32'(e[31:16]));
            check({tag, "_right"}, 32'(f.r), 32'(e[15:0]));
            check({tag, "_format"}, 32'(f.fmt_ok), 32'h1);
        end
    endtask

    task automatic check_pins_zero(input string tag);
        check({tag, "_bclk"}, 32'(sif.BCLK), 32'h0);
        check({tag, "_lrclk"}, 32'(sif.LRCLK), 32'h0);
        check({tag, "_sdout"}, 32'(sif.SDOUT), 32'h0);
        check({tag, "_state"}, 32'(dbg.state), 32'(IDLE));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   smp0;
        int   rise0;

        vecs[0] = '{mode: 1, l1: 16'hA5C3, r1: 16'h0F0F, l2: 16'h0, r2: 16'h0,
                    exp_l: 16'hA5C3, exp_r: 16'h0F0F, exp_ur: 1'b0, clr: 1'b0};
        vecs[1] = '{mode: 0, l1: 16'h0, r1: 16'h0, l2: 16'h0, r2: 16'h0,
                    exp_l: 16'hA5C3, exp_r: 16'h0F0F, exp_ur: 1'b1, clr: 1'b1};
        vecs[2] = '{mode: 2, l1: 16'h1111, r1: 16'h2222, l2: 16'h3333, r2: 16'h4444,
                    exp_l: 16'h3333, exp_r: 16'h4444, exp_ur: 1'b0, clr: 1'b0};
        vecs[3] = '{mode: 3, l1: 16'h8000, r1: 16'h7FFF, l2: 16'h0, r2: 16'h0,
                    exp_l: 16'h8000, exp_r: 16'h7FFF, exp_ur: 1'b0, clr: 1'b0};
        vecs[4] = '{mode: 0, l1: 16'h0, r1: 16'h0, l2: 16'h0, r2: 16'h0,
                    exp_l: 16'h8000, exp_r: 16'h7FFF, exp_ur: 1'b1, clr: 1'b1};

        sif.VALID    = 1'b0;
        sif.left_in  = '0;
        sif.right_in = '0;

        // Reset state
        repeat (3) tick();
        check_pins_zero("reset");
        check("reset_smp_req", 32'(sif.smp_req), 32'h0);
        check("reset_underrun", 32'(underrun), 32'h0);
        check("reset_bit_cnt", 32'(dbg.bit_cnt), 32'(FRAME_BITS - 1));
        rst_n = 1'b1;
        tick();

        // Table: stimulus before load k, underrun after load k, frame k-1 checked after load k
        for (int k = 0; k < 5; k++) begin
            case (vecs[k].mode)
                1: drive_valid(vecs[k].l1, vecs[k].r1);
                2: begin
                    drive_valid(vecs[k].l1, vecs[k].r1);
                    drive_valid(vecs[k].l2, vecs[k].r2);
                end
                3: begin
                    wait_since($sformatf("rec%0d", k), FRAME_CLKS - 1);
                    drive_valid(vecs[k].l1, vecs[k].r1);
                end
                default: ;
            endcase
            exp_q.push_back({vecs[k].exp_l, vecs[k].exp_r});
            if (k == 0) en = 1'b1;
            wait_smp_req($sformatf("rec%0d", k), FRAME_CLKS + 16);
            check($sformatf("rec%0d_underrun", k), 32'(underrun), 32'(vecs[k].exp_ur));
            if (vecs[k].clr) begin
                repeat (10) tick();
                check($sformatf("rec%0d_underrun_sticky", k), 32'(underrun), 32'h1);
                pulse_clr();
                check($sformatf("rec%0d_underrun_clr", k), 32'(underrun), 32'h0);
            end
            if (k > 0) wait_frame($sformatf("rec%0d", k - 1));
        end
        wait_frame("rec4");

        // en dropped mid right slot: frame completes, then the link goes quiet
        wait_smp_req("pre_drain", FRAME_CLKS + 16);
        drive_valid(16'h1234, 16'h5678);
        wait_smp_req("drain_load", FRAME_CLKS + 16);
        got_q.delete();
        exp_q.delete();
        exp_q.push_back(32'h1234_5678);
        pulse_clr();
        wait_since("drain", 160);
        check("drain_lrclk_right", 32'(sif.LRCLK), 32'h1);
        en = 1'b0;
        wait_frame("drain");
        repeat (4) tick();
        check_pins_zero("drained");
        smp0 = smp_cnt;
        rise0 = rise_cnt;
        repeat (300) tick();
        check("drained_no_smp_req", 32'(smp_cnt - smp0), 32'h0);
        check("drained_no_bclk", 32'(rise_cnt - rise0), 32'h0);
        check("drained_underrun", 32'(underrun), 32'h0);
        check("drained_state", 32'(dbg.state), 32'(IDLE));

        // Restart: a pair captured while idle goes out in the first frame
        drive_valid(16'h0BAD, 16'hF00D);
        exp_q.push_back(32'h0BAD_F00D);
        en = 1'b1;
        wait_smp_req("restart", 64);
        check("restart_underrun", 32'(underrun), 32'h0);
        wait_frame("restart");

        // Reset mid left slot with a pair pending: everything returns to zero
        wait_smp_req("pre_reset", FRAME_CLKS + 16);
        drive_valid(16'h5555, 16'h6666);
        wait_since("reset_mid", 40);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_pins_zero("mid_reset");
        check("mid_reset_smp_req", 32'(sif.smp_req), 32'h0);
        check("mid_reset_underrun", 32'(underrun), 32'h0);
        got_q.delete();
        exp_q.delete();
        exp_q.push_back(32'h0);
        wait_smp_req("post_reset", 64);
        check("post_reset_underrun", 32'(underrun), 32'h1);
        wait_frame("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
